// File: rtl/rd_fifo_dispatcher_pkg.sv
// Shared defaults and FSM encoding for the read-return dispatcher.
package rd_fifo_dispatcher_pkg;

  localparam int unsigned RD_CH_NUM    = 6;
  localparam int unsigned RD_DATA_W    = 512;
  localparam int unsigned RD_CID_W     = 3;
  localparam int unsigned RD_LEN_W     = 5;
  localparam int unsigned RD_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TAG_WAIT = 2'd1,
    ST_XFER     = 2'd2,
    ST_DONE     = 2'd3
  } disp_state_t;

endpackage

// File: rtl/rd_dispatch_tag_dec.sv
// Combinational tag decode: {cid, len} -> one-hot channel, expanded length, illegal flag.
// A zero length field encodes 2**LEN_W words.
module rd_dispatch_tag_dec
  import rd_fifo_dispatcher_pkg::*;
#(
  parameter int unsigned CH_NUM = RD_CH_NUM,
  parameter int unsigned CID_W  = RD_CID_W,
  parameter int unsigned LEN_W  = RD_LEN_W
) (
  input  logic [CID_W+LEN_W-1:0] tag,
  output logic [CH_NUM-1:0]      ch_onehot,
  output logic [LEN_W:0]         len,
  output logic                   illegal
);

  logic [CID_W-1:0] cid;
  logic [LEN_W-1:0] len_field;

  assign cid       = tag[LEN_W +: CID_W];
  assign len_field = tag[LEN_W-1:0];
  assign len       = {(len_field == '0), len_field};
  assign illegal   = (32'(cid) >= CH_NUM);

  always_comb begin
    ch_onehot = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (cid == CID_W'(i)) ch_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rd_fifo_dispatcher.sv
// Routes DDR read bursts to per-channel read FIFOs using tags popped in command order.
// Optional macro RD_DISPATCH_ERR_EN enables the sticky illegal-tag flag and counter.
module rd_fifo_dispatcher
  import rd_fifo_dispatcher_pkg::*;
#(
  parameter int unsigned CH_NUM = RD_CH_NUM,
  parameter int unsigned DATA_W = RD_DATA_W,
  parameter int unsigned CID_W  = RD_CID_W,
  parameter int unsigned LEN_W  = RD_LEN_W
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [CID_W+LEN_W-1:0]    rd_tag_fifo_dout,
  input  logic                      rd_tag_fifo_empty,
  input  logic                      rd_tag_fifo_valid,
  output logic                      rd_tag_fifo_rd_en,
  input  logic [DATA_W-1:0]         rd_ddr_fifo_dout,
  input  logic                      rd_ddr_fifo_empty,
  input  logic                      rd_ddr_fifo_valid,
  output logic                      rd_ddr_fifo_rd_en,
  input  logic [CH_NUM-1:0]         ch_rd_fifo_afull,
  output logic [CH_NUM-1:0]         ch_rd_fifo_wr_en,
  output logic [DATA_W-1:0]         ch_rd_fifo_din,
  output logic [CH_NUM-1:0]         ch_burst_done_o,
  output logic                      dispatch_busy_o,
  output logic                      err_o,
  output logic [RD_ERR_CNT_W-1:0]   err_cnt_o
);

  localparam int unsigned CNT_W = LEN_W + 1;

  disp_state_t       state, state_nxt;
  logic [CH_NUM-1:0] dec_onehot, ch_sel;
  logic [CNT_W-1:0]  dec_len, len_q, issued, words_left;
  logic              dec_illegal;
  logic              tag_pop_c, data_pop_c, tag_latch_c, ch_afull_c;

  rd_dispatch_tag_dec #(
    .CH_NUM (CH_NUM),
    .CID_W  (CID_W),
    .LEN_W  (LEN_W)
  ) u_tag_dec (
    .tag       (rd_tag_fifo_dout),
    .ch_onehot (dec_onehot),
    .len       (dec_len),
    .illegal   (dec_illegal)
  );

  // Illegal tags carry an empty channel select, so their afull is ignored.
  assign ch_afull_c = |(ch_rd_fifo_afull & ch_sel);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (!rd_tag_fifo_empty) state_nxt = ST_TAG_WAIT;
      ST_TAG_WAIT: if (rd_tag_fifo_valid) state_nxt = ST_XFER;
      ST_XFER:     if (rd_ddr_fifo_valid && (words_left == CNT_W'(1))) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Pop strobes are combinational so FIFO latency stays at one cycle.
  always_comb begin
    tag_pop_c   = 1'b0;
    data_pop_c  = 1'b0;
    tag_latch_c = 1'b0;
    if (!sys_rst) begin
      case (state)
        ST_IDLE:     tag_pop_c   = !rd_tag_fifo_empty;
        ST_TAG_WAIT: tag_latch_c = rd_tag_fifo_valid;
        ST_XFER:     data_pop_c  = !rd_ddr_fifo_empty && !ch_afull_c && (issued < len_q);
        default:     ;
      endcase
    end
  end

  assign rd_tag_fifo_rd_en = tag_pop_c;
  assign rd_ddr_fifo_rd_en = data_pop_c;

  // Burst context, counters and registered write/done outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ch_sel           <= '0;
      len_q            <= '0;
      issued           <= '0;
      words_left       <= '0;
      ch_rd_fifo_wr_en <= '0;
      ch_rd_fifo_din   <= '0;
      ch_burst_done_o  <= '0;
      dispatch_busy_o  <= 1'b0;
    end else begin
      ch_rd_fifo_wr_en <= '0;
      ch_burst_done_o  <= '0;
      dispatch_busy_o  <= (state_nxt != ST_IDLE);
      if (tag_latch_c) begin
        ch_sel     <= dec_illegal ? '0 : dec_onehot;
        len_q      <= dec_len;
        issued     <= '0;
        words_left <= dec_len;
      end
      if (data_pop_c) issued <= issued + CNT_W'(1);
      if ((state == ST_XFER) && rd_ddr_fifo_valid) begin
        words_left <= words_left - CNT_W'(1);
        if (|ch_sel) begin
          ch_rd_fifo_wr_en <= ch_sel;
          ch_rd_fifo_din   <= rd_ddr_fifo_dout;
        end
      end
      if (state == ST_DONE) ch_burst_done_o <= ch_sel;
    end
  end

`ifdef RD_DISPATCH_ERR_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (tag_latch_c && dec_illegal) begin
      err_o <= 1'b1;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + RD_ERR_CNT_W'(1);
    end
  end
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule
